ex_mem_pipe_reg: RTL
====================

// Module: ex_mem_pipe_reg
// PURPOSE
//  Execute->memory pipeline register directly downstream of the ALU.
//  Captures ALU_OUT plus writeback/store control into a 2-entry skid buffer.
//  Valid/ready handshakes on both sides; flush support for branch/exception kill.
//  Youngest writeback result goes back to the ALU operand muxes as a forward path.
// PARAMETERS
//  WIDTH       32  datapath width: ALU result and store data
//  REG_ADDR_W  4   destination register index width
// PORTS
//  CLK             in   1           clock, rising edge
//  RST_N           in   1           asynchronous reset, active-low
//  FLUSH           in   1           kill all held entries and the current input beat
//  IN_VALID        in   1           execute stage presents a beat
//  IN_READY        out  1           this block can accept a beat
//  IN_ALU_OUT      in   WIDTH       ALU result
//  IN_RD           in   REG_ADDR_W  destination register
//  IN_WE           in   1           register writeback enable
//  IN_MEM_WRITE    in   1           beat is a store (IN_ALU_OUT = address)
//  IN_STORE_DATA   in   WIDTH       store data
//  OUT_VALID       out  1           memory stage beat valid
//  OUT_READY       in   1           memory stage accepts
//  OUT_ALU_OUT     out  WIDTH       oldest entry: result
//  OUT_RD          out  REG_ADDR_W  oldest entry: destination register
//  OUT_WE          out  1           oldest entry: writeback enable
//  OUT_MEM_WRITE   out  1           oldest entry: store flag
//  OUT_STORE_DATA  out  WIDTH       oldest entry: store data
//  FWD_VALID       out  1           forward path valid
//  FWD_RD          out  REG_ADDR_W  forward path: register
//  FWD_DATA        out  WIDTH       forward path: data
// BEHAVIOUR
//  - Transfers: in_fire = IN_VALID & IN_READY; out_fire = OUT_VALID & OUT_READY.
//  - Storage: main entry (drives OUT_*) and skid entry.
//    State EMPTY/ONE/TWO = number of valid entries.
//  - Transitions, when FLUSH=0:
//    - EMPTY: in_fire -> ONE.
//    - ONE:
//      - in_fire & out_fire -> ONE; main takes the new beat.
//      - in_fire only -> TWO; skid takes the new beat.
//      - out_fire only -> EMPTY.
//    - TWO:
//      - out_fire -> ONE; skid moves to main.
//      - in_fire cannot occur in TWO.
//  - IN_READY = (state != TWO). It is a registered decode and never depends on OUT_READY.
//  - OUT_VALID = (state != EMPTY). OUT_* hold steady while OUT_VALID=1 and OUT_READY=0.
//  - Latency: a beat accepted at edge N appears on OUT_* after edge N when the buffer was EMPTY.
//    Otherwise it appears in FIFO order.
//  - Capture rule: WE is stored as IN_WE & (IN_RD != 0), so register 0 is never written back.
//  - Per entry, the data/ctrl fields are don't-care while the entry is invalid.
//  - Forward path:
//    - FWD_* come from the youngest valid entry: skid in TWO, main in ONE.
//    - FWD_VALID = youngest valid & its stored WE & !MEM_WRITE.
//    - FWD_VALID = 0 in EMPTY.
//  - FLUSH:
//    - The next state is EMPTY regardless of in_fire/out_fire in the same cycle.
//    - An out_fire in that cycle still completes: the memory stage owns that beat.
//    - The input beat is dropped.
//    - IN_READY = 1 in the cycle after the flush.
//  - Reset (RST_N=0, asynchronous): state=EMPTY.
//    - OUT_VALID=0, FWD_VALID=0, IN_READY=1.
//    - OUT_* data, FWD_RD and FWD_DATA = 0.
//    - Deasserting reset mid-stream leaves no stale beats.
// STRUCTURE
//  - Shared package ex_pkg:
//    - typedef struct packed ex_payload_t {alu_out, rd, we, mem_write, store_data}.
//    - typedef enum logic[1:0] skid_state_t {EMPTY, ONE, TWO}.
//    - The ALU opcode constants move into ex_pkg as well.
//  - Sub-module: pipe_skid_buffer #(parameter type T = ex_payload_t).
//    - It is the generic 2-entry handshake/state machine with flush.
//    - Exposes its youngest entry for the forward logic.
//  - Top level adds the WE capture rule and the forward-path decode.
// TESTING
//  1. Reset: RST_N=0 mid-stream -> OUT_VALID=0, FWD_VALID=0, IN_READY=1 immediately.
//  2. Streaming:
//     - Stimulus: OUT_READY=1, 4 beats, ALU_OUT=0x11,0x22,0x33,0x44.
//     - Response: identical sequence on OUT_ALU_OUT, 1-cycle latency, no bubbles.
//  3. Backpressure:
//     - Stimulus: OUT_READY=0 while 3 beats are offered.
//     - Response: 2 accepted and IN_READY=0.
//     - Then OUT_READY=1: order 0x11, 0x22, then the third beat is accepted.
//  4. Forward:
//     - RD=5, WE=1, ALU_OUT=0xDEADBEEF held in ONE -> FWD_VALID=1, FWD_RD=5, FWD_DATA=0xDEADBEEF.
//     - RD=0, WE=1 -> OUT_WE=0, FWD_VALID=0.
//  5. Flush:
//     - Stimulus: TWO with OUT_READY=1 and IN_VALID=1, FLUSH=1.
//     - Response: the current out beat completes; next cycle EMPTY, IN_READY=1, input beat dropped.
//  6. Store: MEM_WRITE=1, WE=0, STORE_DATA=0xA5A5A5A5 -> appears on OUT_STORE_DATA; FWD_VALID=0.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared execute-stage definitions.
//   ex_payload_t : one EX->MEM beat (result, destination, writeback/store control)
//   skid_state_t : occupancy of a 2-entry skid buffer
//   alu_op_t     : ALU opcode encodings used by the execute stage
package ex_pkg;

  localparam int EX_WIDTH      = 32;
  localparam int EX_REG_ADDR_W = 4;

  typedef struct packed {
    logic [EX_WIDTH-1:0]      alu_out;
    logic [EX_REG_ADDR_W-1:0] rd;
    logic                     we;
    logic                     mem_write;
    logic [EX_WIDTH-1:0]      store_data;
  } ex_payload_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_t;

endpackage

// File: rtl/pipe_skid_buffer.sv
// Generic 2-entry valid/ready skid buffer with flush.
//   clk, rst_n            : clock, async active-low reset
//   flush                 : empty the buffer, drop the current input beat
//   in_valid/in_ready     : upstream handshake, in_data payload
//   out_valid/out_ready   : downstream handshake, out_data = oldest entry
//   young_valid/young_data: youngest valid entry (skid when full, else main)
// in_ready is a pure decode of the state register, so no combinational
// path runs from out_ready back to in_ready.
module pipe_skid_buffer
  import ex_pkg::*;
#(
  parameter type T = ex_payload_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data,
  output logic young_valid,
  output T     young_data
);

  skid_state_t state, state_nxt;
  T            main_q, skid_q;
  logic        in_fire, out_fire;
  logic        load_main, load_skid, main_from_skid;

  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_nxt      = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state)
      EMPTY: if (in_fire) begin
        state_nxt = ONE;
        load_main = 1'b1;
      end
      ONE: begin
        if (in_fire && out_fire) begin
          load_main = 1'b1;
        end else if (in_fire) begin
          state_nxt = TWO;
          load_skid = 1'b1;
        end else if (out_fire) begin
          state_nxt = EMPTY;
        end
      end
      TWO: if (out_fire) begin
        state_nxt      = ONE;
        main_from_skid = 1'b1;
      end
      default: state_nxt = EMPTY;
    endcase
    // Flush wins over everything; any out_fire this cycle has already been
    // seen by the consumer, the input beat is simply never stored.
    if (flush) begin
      state_nxt      = EMPTY;
      load_main      = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state <= state_nxt;
      if (load_main)           main_q <= in_data;
      else if (main_from_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= in_data;
    end
  end

  assign out_data    = main_q;
  assign young_valid = (state != EMPTY);
  assign young_data  = (state == TWO) ? skid_q : main_q;

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM pipeline register built on a 2-entry skid buffer.
//   clk, rst_n      : clock, async active-low reset
//   flush           : kill held entries and the current input beat
//   in_*            : execute-stage beat and handshake
//   out_*           : memory-stage beat (oldest entry) and handshake
//   fwd_*           : youngest writeback result for the ALU operand muxes
module ex_mem_pipe_reg
  import ex_pkg::*;
#(
  parameter int WIDTH      = EX_WIDTH,
  parameter int REG_ADDR_W = EX_REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_alu_out,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_we,
  input  logic                  in_mem_write,
  input  logic [WIDTH-1:0]      in_store_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_alu_out,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_we,
  output logic                  out_mem_write,
  output logic [WIDTH-1:0]      out_store_data,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_rd,
  output logic [WIDTH-1:0]      fwd_data
);

  typedef struct packed {
    logic [WIDTH-1:0]      alu_out;
    logic [REG_ADDR_W-1:0] rd;
    logic                  we;
    logic                  mem_write;
    logic [WIDTH-1:0]      store_data;
  } payload_t;

  payload_t in_pl, out_pl, young_pl;
  logic     young_valid;

  // x0 is hardwired zero, so its writeback enable is dropped at capture.
  always_comb begin
    in_pl            = '0;
    in_pl.alu_out    = in_alu_out;
    in_pl.rd         = in_rd;
    in_pl.we         = in_we & (in_rd != '0);
    in_pl.mem_write  = in_mem_write;
    in_pl.store_data = in_store_data;
  end

  pipe_skid_buffer #(.T(payload_t)) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_pl),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_pl),
    .young_valid (young_valid),
    .young_data  (young_pl)
  );

  assign out_alu_out    = out_pl.alu_out;
  assign out_rd         = out_pl.rd;
  assign out_we         = out_pl.we;
  assign out_mem_write  = out_pl.mem_write;
  assign out_store_data = out_pl.store_data;

  // Stores carry an address in alu_out, never a register result.
  assign fwd_valid = young_valid & young_pl.we & ~young_pl.mem_write;
  assign fwd_rd    = young_pl.rd;
  assign fwd_data  = young_pl.alu_out;

endmodule
